// File: rtl/core_pipe_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and core_pipe_ctrl.
// The master side is the datapath/caches; the slave side is the controller.
interface core_pipe_ctrl_if;
  logic        l1i_ack_in;
  logic        l1d_req_val_in;
  logic        l1d_ack_in;
  logic [4:0]  dec_rs1_in;
  logic [4:0]  dec_rs2_in;
  logic [1:0]  dec_haz_cmd_in;
  logic        exe_val_in;
  logic        exe_load_in;
  logic [4:0]  exe_rd_in;
  logic        exe_redirect_in;

  logic        if_enb_out;
  logic        dec_enb_out;
  logic        exe_enb_out;
  logic        mem_enb_out;
  logic        wb_enb_out;
  logic        dec_kill_out;
  logic        exe_kill_out;
  logic        stall_out;
  logic [2:0]  state_out;
  logic [31:0] stall_cnt_out;
  logic [31:0] flush_cnt_out;

  modport master (
    output l1i_ack_in, l1d_req_val_in, l1d_ack_in, dec_rs1_in, dec_rs2_in,
           dec_haz_cmd_in, exe_val_in, exe_load_in, exe_rd_in, exe_redirect_in,
    input  if_enb_out, dec_enb_out, exe_enb_out, mem_enb_out, wb_enb_out,
           dec_kill_out, exe_kill_out, stall_out, state_out,
           stall_cnt_out, flush_cnt_out
  );

  modport slave (
    input  l1i_ack_in, l1d_req_val_in, l1d_ack_in, dec_rs1_in, dec_rs2_in,
           dec_haz_cmd_in, exe_val_in, exe_load_in, exe_rd_in, exe_redirect_in,
    output if_enb_out, dec_enb_out, exe_enb_out, mem_enb_out, wb_enb_out,
           dec_kill_out, exe_kill_out, stall_out, state_out,
           stall_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/core_pipe_ctrl.sv
// Five-stage pipeline stall/flush controller: stage enables, bubble kills, FSM state.
// Optional stall/flush performance counters are built when CORE_PIPE_PERF_EN is defined.
module core_pipe_ctrl (
  input  logic             clk,
  input  logic             rst,
  core_pipe_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_IWAIT = 3'd2,
    S_DWAIT = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  // Enable vector order: {if, dec, exe, mem, wb}.
  localparam int EN_IF  = 4;
  localparam int EN_DEC = 3;

  state_t     state, state_nxt;
  logic       flush_pend, flush_pend_nxt;
  logic [4:0] en;
  logic       dec_kill, exe_kill, stall;
  logic       dmem_stall, load_use, use_rs1, use_rs2;

  assign dmem_stall = bus.l1d_req_val_in & ~bus.l1d_ack_in;

  // Reserved command 11 reads both sources, same as 10.
  assign use_rs1  = (bus.dec_haz_cmd_in != 2'b00);
  assign use_rs2  = bus.dec_haz_cmd_in[1];
  assign load_use = bus.exe_val_in & bus.exe_load_in & (bus.exe_rd_in != 5'd0) &
                    ((use_rs1 & (bus.exe_rd_in == bus.dec_rs1_in)) |
                     (use_rs2 & (bus.exe_rd_in == bus.dec_rs2_in)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    flush_pend_nxt = flush_pend;
    en             = 5'b11111;
    dec_kill       = 1'b0;
    exe_kill       = 1'b0;
    stall          = 1'b0;

    if (rst || state == S_INIT) begin
      en             = 5'b00000;
      dec_kill       = 1'b1;
      exe_kill       = 1'b1;
      stall          = 1'b1;
      state_nxt      = S_RUN;
      flush_pend_nxt = 1'b0;
    end else if (dmem_stall) begin
      en        = 5'b00000;
      stall     = 1'b1;
      state_nxt = S_DWAIT;
      // A flush interrupted by a data miss must still run once the miss clears.
      if (state == S_FLUSH) flush_pend_nxt = 1'b1;
    end else if (bus.exe_redirect_in) begin
      dec_kill       = 1'b1;
      exe_kill       = 1'b1;
      state_nxt      = S_FLUSH;
      flush_pend_nxt = 1'b0;
    end else if (state == S_FLUSH) begin
      dec_kill  = 1'b1;
      state_nxt = S_RUN;
    end else if (load_use) begin
      en[EN_IF]  = 1'b0;
      en[EN_DEC] = 1'b0;
      exe_kill   = 1'b1;
      stall      = 1'b1;
      state_nxt  = S_RUN;
    end else if (!bus.l1i_ack_in) begin
      en[EN_IF] = 1'b0;
      dec_kill  = 1'b1;
      stall     = 1'b1;
      state_nxt = S_IWAIT;
    end else begin
      state_nxt = S_RUN;
    end

    if (!rst && state == S_DWAIT && !dmem_stall && flush_pend) begin
      state_nxt      = S_FLUSH;
      flush_pend_nxt = 1'b0;
    end
  end

  assign bus.if_enb_out   = en[4];
  assign bus.dec_enb_out  = en[3];
  assign bus.exe_enb_out  = en[2];
  assign bus.mem_enb_out  = en[1];
  assign bus.wb_enb_out   = en[0];
  assign bus.dec_kill_out = dec_kill;
  assign bus.exe_kill_out = exe_kill;
  assign bus.stall_out    = stall;
  assign bus.state_out    = rst ? S_INIT : state;

`ifdef CORE_PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic        redirect_acc;

  assign redirect_acc = !rst && state != S_INIT && !dmem_stall && bus.exe_redirect_in;

  // NOTE: only control state gets a reset; counters here are true state and
  // must clear, but pure datapath registers elsewhere would not need one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && state != S_INIT && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_acc && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_out = rst ? 32'd0 : stall_cnt;
  assign bus.flush_cnt_out = rst ? 32'd0 : flush_cnt;
`else
  assign bus.stall_cnt_out = 32'd0;
  assign bus.flush_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed-vector bench for core_pipe_ctrl: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_core_pipe_ctrl;

`ifdef CORE_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        rst, iack, dreq, dack;
    logic [4:0]  rs1, rs2;
    logic [1:0]  haz;
    logic        ev, el;
    logic [4:0]  rd;
    logic        redir;
    logic [2:0]  st;
    logic [4:0]  en;
    logic        dk, ek, stall;
    logic [31:0] sc, fc;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [2:0]  st;
    logic [4:0]  en;
    logic [2:0]  ks;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  core_pipe_ctrl_if bus();

  core_pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic ia, input logic dq, input logic da,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] hz,
                     input logic v, input logic l, input logic [4:0] d, input logic rd_x,
                     input logic [2:0] st, input logic [4:0] en, input logic dk,
                     input logic ek, input logic sl, input int sc, input int fc);
    vec_t t;
    t = '{rst:r, iack:ia, dreq:dq, dack:da, rs1:s1, rs2:s2, haz:hz, ev:v, el:l,
          rd:d, redir:rd_x, st:st, en:en, dk:dk, ek:ek, stall:sl,
          sc:32'(sc), fc:32'(fc)};
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    rst                 = t.rst;
    bus.l1i_ack_in      = t.iack;
    bus.l1d_req_val_in  = t.dreq;
    bus.l1d_ack_in      = t.dack;
    bus.dec_rs1_in      = t.rs1;
    bus.dec_rs2_in      = t.rs2;
    bus.dec_haz_cmd_in  = t.haz;
    bus.exe_val_in      = t.ev;
    bus.exe_load_in     = t.el;
    bus.exe_rd_in       = t.rd;
    bus.exe_redirect_in = t.redir;
  endtask

  // Monitor: outputs are valid every cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("state v%0d", e.idx), 32'(bus.state_out), 32'(e.st));
      check($sformatf("enables v%0d", e.idx),
            32'({bus.if_enb_out, bus.dec_enb_out, bus.exe_enb_out, bus.mem_enb_out, bus.wb_enb_out}),
            32'(e.en));
      check($sformatf("kills_stall v%0d", e.idx),
            32'({bus.dec_kill_out, bus.exe_kill_out, bus.stall_out}), 32'(e.ks));
      check($sformatf("stall_cnt v%0d", e.idx), bus.stall_cnt_out, e.sc);
      check($sformatf("flush_cnt v%0d", e.idx), bus.flush_cnt_out, e.fc);
    end
  end

  initial begin
    //   rst ia dq da rs1 rs2 haz  ev el rd rdx  st en        dk ek sl  sc fc
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 5'b00000, 1, 1, 1,  0, 0); // INIT
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  0, 0); // RUN
    add(0, 1, 0, 0, 1, 5, 2'b10, 1, 1, 5, 0,  1, 5'b00111, 0, 1, 1,  0, 0); // rs2 load-use
    add(0, 1, 0, 0, 0, 0, 2'b10, 1, 1, 0, 0,  1, 5'b11111, 0, 0, 0,  1, 0); // rd=0 no stall
    add(0, 1, 0, 0, 3, 5, 2'b01, 1, 1, 5, 0,  1, 5'b11111, 0, 0, 0,  1, 0); // rs2 unused
    add(0, 1, 0, 0, 0, 7, 2'b11, 1, 1, 7, 0,  1, 5'b00111, 0, 1, 1,  1, 0); // reserved=10
    add(0, 1, 0, 0, 7, 0, 2'b00, 1, 1, 7, 0,  1, 5'b11111, 0, 0, 0,  2, 0); // no sources
    add(0, 1, 0, 0, 9, 0, 2'b01, 1, 0, 9, 0,  1, 5'b11111, 0, 0, 0,  2, 0); // not a load
    add(0, 1, 0, 0, 9, 0, 2'b01, 1, 1, 9, 0,  1, 5'b00111, 0, 1, 1,  2, 0); // rs1 load-use
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b00000, 0, 0, 1,  3, 0); // dmem miss
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  3, 5'b00000, 0, 0, 1,  4, 0);
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  3, 5'b00000, 0, 0, 1,  5, 0);
    add(0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0,  3, 5'b11111, 0, 0, 0,  6, 0); // ack cycle
    add(0, 1, 0, 0, 5, 0, 2'b01, 1, 1, 5, 1,  1, 5'b11111, 1, 1, 0,  6, 0); // redirect wins
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  4, 5'b11111, 1, 0, 0,  6, 1); // FLUSH
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  6, 1);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b01111, 1, 0, 1,  6, 1); // ifetch miss
    add(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  2, 5'b01111, 1, 0, 1,  7, 1);
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  2, 5'b11111, 0, 0, 0,  8, 1); // ack in IWAIT
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  8, 1);
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1,  1, 5'b11111, 1, 1, 0,  8, 1); // redirect
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  4, 5'b00000, 0, 0, 1,  8, 2); // miss in FLUSH
    add(0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0,  3, 5'b11111, 0, 0, 0,  9, 2);
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  4, 5'b11111, 1, 0, 0,  9, 2); // FLUSH again
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  9, 2);
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b00000, 0, 0, 1,  9, 2);
    add(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  3, 5'b00000, 0, 0, 1, 10, 2);
    add(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 5'b00000, 1, 1, 1,  0, 0); // rst in DWAIT
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 5'b00000, 1, 1, 1,  0, 0);
    add(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  0, 0);

    drive('{rst:1'b1, iack:1'b1, default:'0});
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      #1;
      drive(vecs[i]);
      e.idx = i;
      e.st  = vecs[i].st;
      e.en  = vecs[i].en;
      e.ks  = {vecs[i].dk, vecs[i].ek, vecs[i].stall};
      e.sc  = PERF ? vecs[i].sc : 32'd0;
      e.fc  = PERF ? vecs[i].fc : 32'd0;
      exp_q.push_back(e);
      @(posedge clk);
    end

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_pipe_ctrl.md
CORE_PIPE_CTRL -- requirements
Module: core_pipe_ctrl

Interface
REQ-001 clk  in  1  core clock; all state on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 l1i_ack_in  in  1  fetch response valid this cycle.
REQ-004 l1d_req_val_in  in  1  mem stage holds a data request.
REQ-005 l1d_ack_in  in  1  data request completes this cycle.
REQ-006 dec_rs1_in / dec_rs2_in  in  5 each  source regs of decode instruction.
REQ-007 dec_haz_cmd_in  in  2  00 no sources, 01 rs1 only, 10 rs1+rs2, 11 reserved (treated as 10).
REQ-008 exe_val_in, exe_load_in  in  1 each  exe instruction valid / is a load.
REQ-009 exe_rd_in  in  5  exe destination reg.
REQ-010 exe_redirect_in  in  1  taken branch/jump resolved in exe.
REQ-011 if_enb_out, dec_enb_out, exe_enb_out, mem_enb_out, wb_enb_out  out  1 each  stage register enables.
REQ-012 dec_kill_out, exe_kill_out  out  1 each  zero the decode/exe output registers (bubble).
REQ-013 stall_out  out  1  any stall condition active.
REQ-014 state_out  out  3  current FSM state.
REQ-015 stall_cnt_out, flush_cnt_out  out  32 each  performance counters.

Function
REQ-016 FSM states SHALL be INIT=0, RUN=1, IWAIT=2, DWAIT=3, FLUSH=4; state registered, all other outputs combinational from state and inputs.
REQ-017 INIT: all enables 0, both kills 1, stall_out 1; next state RUN unconditionally.
REQ-018 Condition priority each cycle SHALL be: dmem stall > redirect > load-use > ifetch stall > normal.
REQ-019 Dmem stall (l1d_req_val_in & !l1d_ack_in): all five enables 0, kills 0, stall_out 1, next state DWAIT; stays DWAIT until l1d_ack_in, the ack cycle behaves as RUN.
REQ-020 Redirect (exe_redirect_in, no dmem stall): all enables 1, dec_kill_out 1, exe_kill_out 1, next state FLUSH.
REQ-021 FLUSH lasts exactly one cycle: all enables 1, dec_kill_out 1 (drops in-flight wrong-path fetch), then RUN; a dmem stall arriving in FLUSH takes priority and FLUSH is re-entered after DWAIT exits.
REQ-022 Load-use: exe_val_in & exe_load_in & exe_rd_in!=0 & (haz_cmd!=00 & rd==rs1 | haz_cmd>=10 & rd==rs2); if_enb_out 0, dec_enb_out 0, exe_kill_out 1, mem/wb enables 1, stall_out 1; one-cycle bubble, state stays RUN.
REQ-023 Ifetch stall (!l1i_ack_in in RUN/IWAIT): if_enb_out 0, dec_kill_out 1, other enables 1, stall_out 1, next state IWAIT; l1i_ack_in returns to RUN the same cycle it is seen.
REQ-024 Normal: all enables 1, kills 0, stall_out 0.
REQ-025 exe_rd_in==0 SHALL never cause a load-use stall.

Reset
REQ-026 rst sampled at clk edge forces state INIT next cycle regardless of current state, including mid-DWAIT/FLUSH.
REQ-027 While rst is high outputs SHALL equal INIT values; counters clear to 0.

Configuration
REQ-028 Macro CORE_PIPE_PERF_EN defined: stall_cnt_out increments each cycle stall_out=1 outside INIT, flush_cnt_out increments on each redirect acceptance; both saturate at 32'hFFFFFFFF.
REQ-029 Macro undefined: counter logic absent, both ports tied to 0; all other behaviour identical.

Verification
REQ-030 rst 1 cycle, then idle inputs with l1i_ack_in=1 -> one INIT cycle (kills=1), then RUN with all enables 1.
REQ-031 exe load rd=5, dec rs2=5, haz_cmd=10 -> one cycle if/dec_enb 0, exe_kill 1; with rd=0 -> no stall.
REQ-032 l1d_req_val_in=1, ack after 3 cycles -> 3 cycles all enables 0, state 3; ack cycle enables 1.
REQ-033 exe_redirect_in together with load-use -> redirect wins: dec/exe kill 1, next cycle FLUSH, then RUN; flush_cnt_out +1 (PERF_EN).
REQ-034 l1i_ack_in=0 for 2 cycles -> if_enb 0, dec_kill 1 for 2 cycles, state IWAIT, stall_cnt_out +2 (PERF_EN).
REQ-035 rst asserted during DWAIT -> next cycle INIT, counters 0, then RUN.
